// File: rtl/sort_8_stream_tx_if.sv
// sort_8_stream_tx_if: vector-in / word-out stream bundle for sort_8_stream_tx
interface sort_8_stream_tx_if #(parameter int DATA_W = 32);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_0, data_1, data_2, data_3, data_4, data_5, data_6, data_7;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_idx;
  logic              out_last;
  logic              order_err;
  modport slave (
    input  in_valid, data_0, data_1, data_2, data_3, data_4, data_5, data_6, data_7, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last, order_err
  );
  modport master (
    output in_valid, data_0, data_1, data_2, data_3, data_4, data_5, data_6, data_7, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last, order_err
  );
endinterface

// File: rtl/sort_8_stream_tx.sv
// sort_8_stream_tx: serialises one sorted 8-word vector per handshake, rank 0 first.
// Optional SORT_STREAM_CHECK_EN adds a sticky descending-pair detector on order_err.
module sort_8_stream_tx #(
  parameter int DATA_W = 32,
  parameter int N      = 8
) (
  input logic              clk,
  input logic              rst_n,
  sort_8_stream_tx_if.slave bus
);
  typedef enum logic {IDLE, STREAM} state_t;
  state_t            state, state_nxt;
  logic [2:0]        idx, idx_nxt;
  logic [DATA_W-1:0] mem [N];
  logic [DATA_W-1:0] din [N];
  logic              fire, last, load;
  assign din = '{bus.data_0, bus.data_1, bus.data_2, bus.data_3,
                 bus.data_4, bus.data_5, bus.data_6, bus.data_7};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  // Accepting a new vector on the last beat keeps the stream gap-free.
  always_comb begin
    fire          = state == STREAM && bus.out_ready;
    last          = fire && idx == 3'(N - 1);
    bus.in_ready  = state == IDLE || last;
    load          = bus.in_valid && bus.in_ready;
    state_nxt     = load ? STREAM : last ? IDLE : state;
    idx_nxt       = load ? 3'd0 : fire ? idx + 3'd1 : idx;
    bus.out_valid = state == STREAM;
    bus.out_data  = bus.out_valid ? mem[idx] : '0;
    bus.out_idx   = bus.out_valid ? idx : 3'd0;
    bus.out_last  = bus.out_valid && idx == 3'(N - 1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= 3'd0;
      for (int i = 0; i < N; i++) mem[i] <= '0;
    end else begin
      idx <= idx_nxt;
      if (load) mem <= din;
    end
`ifdef SORT_STREAM_CHECK_EN
  logic [DATA_W-1:0] prev;
  logic              err;
  // idx 0 is never compared, so vector boundaries are not checked.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev <= '0;
      err  <= 1'b0;
    end else if (fire) begin
      prev <= bus.out_data;
      if (idx != 3'd0 && bus.out_data < prev) err <= 1'b1;
    end
  assign bus.order_err = err;
`else
  assign bus.order_err = 1'b0;
`endif
endmodule
